// File: rtl/sprite_layer.sv
// Single-sprite pixel layer: double-buffered position regs, ROM fetch, palette.
// Optional SPRITE_SCALE2X_EN adds a per-sprite 2x scale bit (wd[26]).
module sprite_layer #(
  parameter int REG_BASE    = 0,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int FRAMES      = 16,
  parameter int VBLANK_LINE = 480,
  parameter int ROM_AW      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [2:0]        address,
  input  logic [31:0]       writedata,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [23:0]       RGB_output
);

  localparam int FW = $clog2(FRAMES);
  localparam int WW = $clog2(SPR_W);
  localparam int HW = $clog2(SPR_H);
  localparam logic [23:0] TRANSP = 24'h202020;

  logic [9:0]    p_x, p_y, a_x, a_y;
  logic [FW-1:0] p_frame, a_frame;
  logic          p_flip, a_flip;
  logic          p_vis, a_vis;
`ifdef SPRITE_SCALE2X_EN
  logic          p_scale, a_scale;
`endif
  logic [23:0]   palette [16];

  logic          pos_wr, pal_wr, commit;
  logic [10:0]   dx, dy, lim_w, lim_h;
  logic [WW-1:0] cx, col;
  logic [HW-1:0] ry;
  logic          hit, hit1, hit2;
  logic [ROM_AW-1:0] next_addr;

  // bits [31:28] of the bus word carry nothing for this block
  logic unused_wd;
  assign unused_wd = ^writedata[31:28];

  assign pos_wr = write && (address == 3'(REG_BASE));
  assign pal_wr = write && (address == 3'(REG_BASE + 1));
  assign commit = (hcount == 10'd0) && (vcount == 10'(VBLANK_LINE));

  // hit test and ROM address for the pixel currently on hcount/vcount
  always_comb begin
    dx = {1'b0, hcount} - {1'b0, a_x};
    dy = {1'b0, vcount} - {1'b0, a_y};
`ifdef SPRITE_SCALE2X_EN
    lim_w = a_scale ? 11'(2 * SPR_W) : 11'(SPR_W);
    lim_h = a_scale ? 11'(2 * SPR_H) : 11'(SPR_H);
    cx    = a_scale ? dx[WW:1] : dx[WW-1:0];
    ry    = a_scale ? dy[HW:1] : dy[HW-1:0];
`else
    lim_w = 11'(SPR_W);
    lim_h = 11'(SPR_H);
    cx    = dx[WW-1:0];
    ry    = dy[HW-1:0];
`endif
    hit = a_vis && (hcount >= a_x) && (vcount >= a_y)
          && (dx < lim_w) && (dy < lim_h);
    col = a_flip ? (WW'(SPR_W - 1) - cx) : cx;
    next_addr = ROM_AW'({a_frame, ry, col});
  end

  // bus writes into pending/palette, vblank commit into active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_x <= '0; p_y <= '0; p_frame <= '0;
      p_flip <= 1'b0; p_vis <= 1'b0;
      a_x <= '0; a_y <= '0; a_frame <= '0;
      a_flip <= 1'b0; a_vis <= 1'b0;
`ifdef SPRITE_SCALE2X_EN
      p_scale <= 1'b0; a_scale <= 1'b0;
`endif
      for (int i = 0; i < 16; i++) palette[i] <= TRANSP;
    end else begin
      if (commit) begin
        a_x     <= p_x;
        a_y     <= p_y;
        a_frame <= p_frame;
        a_flip  <= p_flip;
        a_vis   <= p_vis;
`ifdef SPRITE_SCALE2X_EN
        a_scale <= p_scale;
`endif
      end
      if (pos_wr) begin
        p_x     <= writedata[9:0];
        p_y     <= writedata[19:10];
        p_frame <= writedata[20 +: FW];
        p_flip  <= writedata[24];
        p_vis   <= writedata[25];
`ifdef SPRITE_SCALE2X_EN
        p_scale <= writedata[26];
`endif
      end
      if (pal_wr) palette[writedata[27:24]] <= writedata[23:0];
    end
  end

  // three-stage fetch: address, ROM read, palette resolve
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr   <= '0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      RGB_output <= TRANSP;
    end else begin
      rom_addr   <= hit ? next_addr : '0;
      hit1       <= hit;
      hit2       <= hit1;
      RGB_output <= (hit2 && rom_data != 4'd0) ? palette[rom_data] : TRANSP;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed + randomized bench for sprite_layer against a pixel-level model.
// Model tracks pending/active copies, palette and a 3-deep sample history.
module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [9:0]  hcount, vcount;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic [23:0] RGB_output;

  always #5 clk = ~clk;

  sprite_layer dut (
    .clk(clk), .reset(reset), .write(write), .address(address),
    .writedata(writedata), .hcount(hcount), .vcount(vcount),
    .rom_addr(rom_addr), .rom_data(rom_data), .RGB_output(RGB_output)
  );

  logic [3:0] rom_mem [4096];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  int p_x, p_y, p_f, p_fl, p_v, p_s;
  int a_x, a_y, a_f, a_fl, a_v, a_s;
  logic [23:0] m_pal [16];
  int h_hit [3];
  int h_addr [3];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    p_x = 0; p_y = 0; p_f = 0; p_fl = 0; p_v = 0; p_s = 0;
    a_x = 0; a_y = 0; a_f = 0; a_fl = 0; a_v = 0; a_s = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = 24'h202020;
    for (int i = 0; i < 3; i++) begin h_hit[i] = 0; h_addr[i] = 0; end
  endfunction

  function automatic logic [31:0] pos_w(int x, int y, int f, int fl,
                                        int v, int s);
    logic [31:0] w;
    w = '0;
    w[9:0] = 10'(x); w[19:10] = 10'(y); w[23:20] = 4'(f);
    w[24] = fl[0]; w[25] = v[0]; w[26] = s[0];
    return w;
  endfunction

  function automatic logic [31:0] pal_w(int i, logic [23:0] c);
    return {4'h0, 4'(i), c};
  endfunction

  task automatic tick(input int hc_i, input int vc_i, input bit wr,
                      input int ad, input logic [31:0] wd);
    int hc, vc, dx, dy, sc, hit, addr, col, idx;
    logic [23:0] exp_rgb;
    @(negedge clk);
    hcount = 10'(hc_i); vcount = 10'(vc_i);
    write = wr; address = 3'(ad); writedata = wd;
    hc = int'(hcount); vc = int'(vcount);
`ifdef SPRITE_SCALE2X_EN
    sc = (a_s != 0) ? 2 : 1;
`else
    sc = 1;
`endif
    dx = hc - a_x; dy = vc - a_y;
    hit = (a_v != 0 && dx >= 0 && dy >= 0 && dx < 16 * sc && dy < 16 * sc);
    col = (a_fl != 0) ? 15 - dx / sc : dx / sc;
    addr = hit ? a_f * 256 + (dy / sc) * 16 + col : 0;
    h_hit[2] = h_hit[1]; h_addr[2] = h_addr[1];
    h_hit[1] = h_hit[0]; h_addr[1] = h_addr[0];
    h_hit[0] = hit;      h_addr[0] = addr;
    idx = int'(rom_mem[h_addr[2]]);
    exp_rgb = (h_hit[2] != 0 && idx != 0) ? m_pal[idx] : 24'h202020;
    if (wr && ad == 1) m_pal[wd[27:24]] = wd[23:0];
    if (hc == 0 && vc == 480) begin
      a_x = p_x; a_y = p_y; a_f = p_f; a_fl = p_fl; a_v = p_v; a_s = p_s;
    end
    if (wr && ad == 0) begin
      p_x = int'(wd[9:0]); p_y = int'(wd[19:10]); p_f = int'(wd[23:20]);
      p_fl = int'(wd[24]); p_v = int'(wd[25]); p_s = int'(wd[26]);
    end
    @(posedge clk); #1;
    chk("rgb", {8'h0, RGB_output}, {8'h0, exp_rgb});
    chk("rom_addr", {20'h0, rom_addr}, 32'(addr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1000, 1000, 0, 0, 0);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input bit pal_noise);
    for (int v = y0; v <= y1; v++)
      for (int h = x0; h <= x1; h++)
        if (pal_noise && $urandom_range(0, 15) == 0)
          tick(h, v, 1, 1, pal_w($urandom_range(0, 15), 24'($urandom)));
        else
          tick(h, v, 0, 0, 0);
    idle(3);
  endtask

  task automatic commit();
    tick(0, 480, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; address = '0; writedata = '0;
    hcount = '0; vcount = '0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd0;
    model_reset();
    #12;
    chk("reset_rgb", {8'h0, RGB_output}, 32'h202020);
    chk("reset_rom_addr", {20'h0, rom_addr}, 32'h0);
    @(negedge clk); reset = 1'b0;

    // idle raster with no writes
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 799), $urandom_range(0, 524), 0, 0, 0);

    // solid sprite at (100,50)
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd3;
    tick(1000, 1000, 1, 1, pal_w(3, 24'hFF0000));
    tick(1000, 1000, 1, 0, pos_w(100, 50, 0, 0, 1, 0));
    commit();
    scan(96, 120, 48, 67, 0);

    // flipped sprite, ROM holds column number
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'(i);
    for (int i = 1; i < 16; i++)
      tick(1000, 1000, 1, 1, pal_w(i, 24'($urandom)));
    tick(1000, 1000, 1, 0, pos_w(100, 50, 5, 1, 1, 0));
    commit();
    tick(100, 50, 0, 0, 0);
    chk("flip_dx0", {28'h0, rom_addr[3:0]}, 32'd15);
    tick(115, 50, 0, 0, 0);
    chk("flip_dx15", {28'h0, rom_addr[3:0]}, 32'd0);
    idle(3);
    scan(98, 118, 49, 52, 0);

    // right-edge clipping, no wrap
    tick(1000, 1000, 1, 0, pos_w(632, 200, 2, 0, 1, 0));
    commit();
    scan(626, 639, 199, 217, 0);
    scan(0, 10, 199, 217, 0);

    // position write landing on the commit cycle
    tick(1000, 1000, 1, 0, pos_w(300, 100, 1, 0, 1, 0));
    commit();
    tick(1000, 1000, 1, 0, pos_w(320, 120, 1, 0, 1, 0));
    tick(0, 480, 1, 0, pos_w(340, 140, 1, 0, 1, 0));
    scan(316, 360, 118, 141, 0);
    commit();
    scan(316, 360, 118, 157, 0);

    // reset pulsed mid-line inside the sprite
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd3;
    tick(1000, 1000, 1, 1, pal_w(3, 24'hFF0000));
    tick(1000, 1000, 1, 0, pos_w(100, 50, 0, 0, 1, 0));
    commit();
    for (int h = 95; h <= 105; h++) tick(h, 55, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("midline_reset_rgb", {8'h0, RGB_output}, 32'h202020);
    chk("midline_reset_addr", {20'h0, rom_addr}, 32'h0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    scan(96, 120, 48, 67, 0);
    commit();
    scan(96, 120, 48, 67, 0);
    tick(1000, 1000, 1, 1, pal_w(3, 24'hFF0000));
    tick(1000, 1000, 1, 0, pos_w(100, 50, 0, 0, 1, 0));
    commit();
    scan(96, 120, 48, 67, 0);

`ifdef SPRITE_SCALE2X_EN
    // 2x scaled footprint
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'(i);
    for (int i = 1; i < 16; i++)
      tick(1000, 1000, 1, 1, pal_w(i, 24'($urandom)));
    tick(1000, 1000, 1, 0, pos_w(100, 50, 3, 1, 1, 1));
    commit();
    scan(96, 135, 48, 60, 0);
    scan(96, 135, 78, 84, 0);
`endif

    // randomized sprites with stray writes and palette noise
    for (int it = 0; it < 6; it++) begin
      int x, y, s;
      x = $urandom_range(0, 640);
      y = $urandom_range(0, 400);
`ifdef SPRITE_SCALE2X_EN
      s = $urandom_range(0, 1);
`else
      s = 0;
`endif
      for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom);
      for (int i = 0; i < 16; i++)
        tick(1000, 1000, 1, 1, pal_w(i, 24'($urandom)));
      tick(1000, 1000, 1, 0,
           pos_w(x, y, $urandom_range(0, 15), $urandom_range(0, 1),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1)));
      if (s == 0) tick(1000, 1000, 0, 0, 0);
      tick(1000, 1000, 1, $urandom_range(2, 7), $urandom);
      commit();
      tick(1000, 1000, 1, $urandom_range(2, 7), $urandom);
      scan(x - 3, x + 35, y - 2, y + 3, 1);
      scan(x - 3, x + 35, y + 14, y + 18, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
Name: sprite_layer

Overview:
- Single-sprite pixel engine, directly upstream of the ppu priority mux. Each instance drives one RGB_list slot.
- Takes position, frame, flip and visibility writes from the Avalon bus. These are double-buffered and committed at vertical blank.
- Fetches 4-bit palette indices from an external synchronous sprite ROM and resolves them through a 16-entry palette.
- Emits 24'h202020, the codebase transparent key, wherever the sprite does not cover the pixel.

Parameters:
- REG_BASE, 0: bus address of this instance's position register. Its palette register is REG_BASE+1.
- SPR_W, 16: sprite width in pixels (power of 2).
- SPR_H, 16: sprite height in pixels (power of 2).
- FRAMES, 16: animation frames held in ROM (power of 2).
- VBLANK_LINE, 480: vcount value at which pending registers are committed.
- ROM_AW, 12: ROM address width, equal to log2(FRAMES*SPR_W*SPR_H).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- write  in  1  bus write strobe
- address  in  3  bus register address
- writedata  in  32  bus write data
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- rom_addr  out  ROM_AW  sprite ROM address (registered)
- rom_data  in  4  palette index, valid one clock after rom_addr
- RGB_output  out  24  pixel colour, or 24'h202020 when transparent

Behaviour:
- Position register write: write=1 and address==REG_BASE. Fields loaded into the pending copy:
  - x = wd[9:0]
  - y = wd[19:10]
  - frame = wd[23:20] (truncated to log2 FRAMES bits)
  - flip = wd[24]
  - visible = wd[25]
- Palette register write: write=1 and address==REG_BASE+1.
  - Writes palette[wd[27:24]] = wd[23:0] immediately.
  - Writes to palette index 0 are stored but never used.
- Other addresses: ignored.
- Commit: on the cycle where hcount==0 and vcount==VBLANK_LINE, the active copy is loaded from pending.
  - If a position write lands in the same cycle, commit takes the old pending value. The new write lands in pending and takes effect at the next commit.
- Hit test, computed in 11 bits with no wrap:
  - dx = hcount - x, dy = vcount - y
  - hit = visible, hcount>=x, vcount>=y, dx<SPR_W and dy<SPR_H
  - A sprite extending past column 639 or row 479 is clipped. It never reappears at the left or top edge.
- Column: col = flip ? SPR_W-1-dx : dx.
- ROM address: rom_addr = frame*SPR_W*SPR_H + dy*SPR_W + col.
- Pipeline, with (hcount, vcount) sampled at edge N:
  - N+1: rom_addr and hit1 are registered.
  - N+2: rom_data is valid; hit2 is registered.
  - N+3: RGB_output is registered.
  - Fixed latency is 3 clocks. Every layer feeding the mux uses the same latency.
- RGB_output = (hit2 and idx!=0) ? palette[idx] : 24'h202020.
- Reset, asynchronous:
  - RGB_output = 24'h202020, rom_addr = 0, hit1/hit2 = 0.
  - Active and pending registers are all 0, so visible=0.
  - All palette entries = 24'h202020.
  - Reset asserted mid-line forces transparent output on the same edge.
  - After deassert, output stays transparent until a visible commit occurs.
- No state depends on hcount/vcount other than the commit strobe. A missing or skipped VBLANK_LINE simply delays the commit.

Optional Feature:
- Macro: SPRITE_SCALE2X_EN.
- Defined:
  - wd[26] of the position write is a scale bit, stored in pending/active like the other fields.
  - With scale=1 the footprint is 2*SPR_W x 2*SPR_H.
  - dx and dy are halved (>>1) before the column/ROM calculation. Flip is applied after halving.
  - Latency is unchanged.
- Undefined: wd[26] is ignored and no scale register exists.

Test Plan:
- Reset, then full frame with no writes -> RGB_output==24'h202020 every cycle; rom_addr==0 after reset.
- Palette idx 3 = 24'hFF0000; position write x=100, y=50, frame=0, visible=1; commit at vcount=480; ROM returns 3 everywhere -> on the next frame, RGB_output==24'hFF0000 for hcount 100..115, rows 50..65, exactly 3 clocks after each sample; 202020 elsewhere.
- Same setup, flip=1, ROM content = column number -> dx=0 drives rom_addr low bits 15; dx=15 drives 0.
- x=632 -> hit only for hcount 632..639; hcount 0..7 of the same rows are transparent (no wrap).
- Position write issued on the exact commit cycle -> the previous pending value displays this frame; the new value displays one frame later.
- Reset pulsed at hcount=105 inside the sprite -> RGB_output==24'h202020 immediately; sprite absent until rewritten and committed. With SPRITE_SCALE2X_EN defined, scale=1 at x=100 -> hit spans hcount 100..131.
